sc_register_point: RTL and testbench
====================================

Name: sc_register_point

Overview:
- Point-position datapath register driven by the point state machine's clear/load/shift commands; it is the responder end of that command interface.
- Holds a one-hot car/point position, shifts it left or right on command, and returns the active-low side-comparator flag that the FSM uses to gate moves.
- Sits between the point FSM and the matrix/display logic; also reports move statistics and protocol errors.

Parameters:
- DATAWIDTH, 8, width of the point register (number of lanes/columns); minimum 2.
- LOAD_VALUE, 8'b0001_0000, value written on a load command; must be one-hot.
- COUNTWIDTH, 8, width of the successful-move counter.

Ports:
- SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- SC_STATEMACHINEPOINT_RESET_InHigh  in  1  asynchronous, active-high reset.
- clear_InLow  in  1  clear command from FSM, active low.
- load_InLow  in  1  load command from FSM, active low.
- shiftselection_In  in  2  01 = shift left, 10 = shift right, 11 = hold, 00 = illegal.
- leftButton_InLow  in  1  raw left request, active low; used only for the comparator.
- rightButton_InLow  in  1  raw right request, active low; used only for the comparator.
- data_Out  out  DATAWIDTH  current point register.
- sidecomparator_OutLow  out  1  low when the requested move is blocked at an edge.
- moveCount_Out  out  COUNTWIDTH  successful shifts since the last clear; saturating.
- error_OutHigh  out  1  sticky flag set on protocol error.

Behaviour:
- Reset (asynchronous): data_Out = 0, moveCount_Out = 0, error_OutHigh = 0. sidecomparator_OutLow then evaluates to 1, because a zero register is never at an edge.
- Per-clock priority:
  1. clear_InLow = 0 → data_Out = 0; moveCount_Out = 0; error_OutHigh = 0.
  2. else load_InLow = 0 → data_Out = LOAD_VALUE; counter unchanged.
  3. else shiftselection_In applies (latency 1 clock).
- Shift left (01): if data_Out[DATAWIDTH-1] = 0, data_Out <= data_Out << 1 and the counter increments (saturates at all-ones). Otherwise hold, with no increment.
- Shift right (10): if data_Out[0] = 0, data_Out <= data_Out >> 1 and the counter increments. Otherwise hold.
- Hold (11): no change.
- Illegal (00) with clear and load both inactive: hold, and set error_OutHigh = 1.
- Clear and load asserted in the same cycle: clear wins, and error_OutHigh <= 1 in that same edge. This overrides clear's reset of the flag.
- Any command (shift or load) while data_Out is not one-hot and non-zero: execute it and set error_OutHigh = 1. This protects against corrupted state.
- Shift while data_Out = 0: register stays 0, counter increments.
- Comparator (combinational from registered data and buttons; no path from command inputs):
  - sidecomparator_OutLow = 0 when (leftButton_InLow = 0 and data_Out[DATAWIDTH-1] = 1), or (rightButton_InLow = 0 and data_Out[0] = 1).
  - Otherwise 1.
  - Both buttons pressed: low if either edge condition holds.
- Reset asserted mid-operation overrides everything immediately. Deassertion takes effect at the next rising clock.

Optional Feature:
- Macro SC_REGISTER_POINT_WRAP_EN.
- Defined:
  - A shift at an edge wraps: left from MSB gives bit 0; right from bit 0 gives MSB.
  - The counter increments on a wrap.
  - sidecomparator_OutLow is tied to 1.
- Undefined: edge-blocking behaviour exactly as in Behaviour.

Test Plan:
- Reset, then clear = 0 for one cycle, then load = 0 for one cycle → data_Out = 8'h00 then 8'h10; moveCount_Out = 0; error_OutHigh = 0.
- From 8'h10, apply shiftselection = 01 for 3 cycles, then 01 once more → 8'h20, 8'h40, 8'h80, then holds at 8'h80; moveCount_Out = 3. With leftButton_InLow = 0, sidecomparator_OutLow = 0; with rightButton_InLow = 0, it is 1.
- From 8'h10, apply shiftselection = 10 for 5 cycles → 8'h01 after 4 shifts, then hold; moveCount_Out = 4. With rightButton_InLow = 0, sidecomparator_OutLow = 0.
- shiftselection = 00 with clear/load inactive → data_Out unchanged, error_OutHigh = 1 and stays 1. Next clear → error_OutHigh = 0, data_Out = 0.
- clear = 0 and load = 0 together → data_Out = 0, error_OutHigh = 1. Then assert reset mid-shift sequence → all outputs 0 asynchronously.
- With SC_REGISTER_POINT_WRAP_EN defined, from 8'h80 apply shift left → 8'h01, moveCount_Out increments, sidecomparator_OutLow = 1.

Source files
------------

// File: rtl/sc_register_point.sv
// Point-position register: one-hot car/point position shifted by the point FSM's clear/load/shift commands.
// Optional macro SC_REGISTER_POINT_WRAP_EN makes edge shifts wrap around instead of blocking.
module sc_register_point #(
  parameter int                   DATAWIDTH  = 8,
  parameter logic [DATAWIDTH-1:0] LOAD_VALUE = 8'b0001_0000,
  parameter int                   COUNTWIDTH = 8
) (
  input  logic                  SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                  SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                  clear_InLow,
  input  logic                  load_InLow,
  input  logic [1:0]            shiftselection_In,
  input  logic                  leftButton_InLow,
  input  logic                  rightButton_InLow,
  output logic [DATAWIDTH-1:0]  data_Out,
  output logic                  sidecomparator_OutLow,
  output logic [COUNTWIDTH-1:0] moveCount_Out,
  output logic                  error_OutHigh
);

  // Command interface: clear_InLow, load_InLow and shiftselection_In are levels sampled on
  // every rising clock (no valid/ready pair); clear beats load, load beats shift, and the
  // result is visible one clock later. This block always accepts a command.

  localparam logic [DATAWIDTH-1:0]  ONE_DATA  = {{(DATAWIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTWIDTH-1:0] ONE_COUNT = {{(COUNTWIDTH-1){1'b0}}, 1'b1};

  logic [DATAWIDTH-1:0]  dataReg, dataNext;
  logic [COUNTWIDTH-1:0] countReg, countNext, countBumped;
  logic                  errorReg, errorNext;
  logic                  corruptState;
  logic                  atLeftEdge, atRightEdge;

  assign atLeftEdge   = dataReg[DATAWIDTH-1];
  assign atRightEdge  = dataReg[0];
  // More than one bit set means the position register is corrupted.
  assign corruptState = (dataReg != '0) && ((dataReg & (dataReg - ONE_DATA)) != '0);
  assign countBumped  = (countReg == '1) ? countReg : countReg + ONE_COUNT;

  always_comb begin
    dataNext  = dataReg;
    countNext = countReg;
    errorNext = errorReg;
    if (!clear_InLow) begin
      dataNext  = '0;
      countNext = '0;
      errorNext = !load_InLow;
    end else if (!load_InLow) begin
      dataNext  = LOAD_VALUE;
      errorNext = errorReg | corruptState;
    end else begin
      case (shiftselection_In)
        2'b01: begin
          errorNext = errorReg | corruptState;
          if (!atLeftEdge) begin
            dataNext  = {dataReg[DATAWIDTH-2:0], 1'b0};
            countNext = countBumped;
          end else begin
`ifdef SC_REGISTER_POINT_WRAP_EN
            dataNext  = {dataReg[DATAWIDTH-2:0], dataReg[DATAWIDTH-1]};
            countNext = countBumped;
`else
            dataNext  = dataReg;
`endif
          end
        end
        2'b10: begin
          errorNext = errorReg | corruptState;
          if (!atRightEdge) begin
            dataNext  = {1'b0, dataReg[DATAWIDTH-1:1]};
            countNext = countBumped;
          end else begin
`ifdef SC_REGISTER_POINT_WRAP_EN
            dataNext  = {dataReg[0], dataReg[DATAWIDTH-1:1]};
            countNext = countBumped;
`else
            dataNext  = dataReg;
`endif
          end
        end
        2'b00:   errorNext = 1'b1;
        default: dataNext  = dataReg;
      endcase
    end
  end

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      dataReg  <= '0;
      countReg <= '0;
      errorReg <= 1'b0;
    end else begin
      dataReg  <= dataNext;
      countReg <= countNext;
      errorReg <= errorNext;
    end
  end

`ifdef SC_REGISTER_POINT_WRAP_EN
  assign sidecomparator_OutLow = 1'b1;
`else
  assign sidecomparator_OutLow = !((!leftButton_InLow && atLeftEdge) ||
                                   (!rightButton_InLow && atRightEdge));
`endif

  assign data_Out      = dataReg;
  assign moveCount_Out = countReg;
  assign error_OutHigh = errorReg;

endmodule

// File: tb/tb_sc_register_point.sv
// Bench for sc_register_point: directed steps plus random commands against a position/count model.
module tb_sc_register_point;

  localparam int W       = 8;
  localparam int CW      = 8;
  localparam int LOADPOS = 4;
  localparam int CNTMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clearN, loadN, leftN, rightN;
  logic [1:0]    sel;
  logic [W-1:0]  dataOut;
  logic          scOut;
  logic [CW-1:0] cntOut;
  logic          errOut;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Model: position index (-1 = empty register), move count, sticky error.
  int            mPos;
  int            mCnt;
  bit            mErr;
  logic [W-1:0]  exp_q[$];

  sc_register_point dut (
    .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
    .clear_InLow                       (clearN),
    .load_InLow                        (loadN),
    .shiftselection_In                 (sel),
    .leftButton_InLow                  (leftN),
    .rightButton_InLow                 (rightN),
    .data_Out                          (dataOut),
    .sidecomparator_OutLow             (scOut),
    .moveCount_Out                     (cntOut),
    .error_OutHigh                     (errOut)
  );

  // Clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] posToData(int p);
    logic [W-1:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  function automatic bit expectedSide();
`ifdef SC_REGISTER_POINT_WRAP_EN
    return 1'b1;
`else
    return !((!leftN && mPos == W-1) || (!rightN && mPos == 0));
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump();
    if (mCnt < CNTMAX) mCnt++;
  endtask

  task automatic modelReset();
    mPos = -1;
    mCnt = 0;
    mErr = 1'b0;
    exp_q.push_back(posToData(mPos));
  endtask

  task automatic modelCommand(bit c, bit l, logic [1:0] s);
    if (!c) begin
      mPos = -1;
      mCnt = 0;
      mErr = !l;
    end else if (!l) begin
      mPos = LOADPOS;
    end else begin
      case (s)
        2'b01: begin
          if (mPos < W-1) begin
            if (mPos >= 0) mPos++;
            bump();
          end
`ifdef SC_REGISTER_POINT_WRAP_EN
          else begin
            mPos = 0;
            bump();
          end
`endif
        end
        2'b10: begin
          if (mPos != 0) begin
            if (mPos > 0) mPos--;
            bump();
          end
`ifdef SC_REGISTER_POINT_WRAP_EN
          else begin
            mPos = W-1;
            bump();
          end
`endif
        end
        2'b00:   mErr = 1'b1;
        default: ;
      endcase
    end
    exp_q.push_back(posToData(mPos));
  endtask

  // Scoreboard: pop the expected register value and compare every output.
  task automatic checkAll(string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'(0), 32'(1));
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".data"},  32'(dataOut), 32'(e));
    check({tag, ".count"}, 32'(cntOut),  32'(mCnt));
    check({tag, ".error"}, 32'(errOut),  32'(mErr));
    check({tag, ".side"},  32'(scOut),   32'(expectedSide()));
  endtask

  // Driver: apply one command for one clock, then check 1 ns after the edge.
  task automatic step(string tag, bit c, bit l, logic [1:0] s, bit lb, bit rb);
    clearN = c;
    loadN  = l;
    sel    = s;
    leftN  = lb;
    rightN = rb;
    @(posedge clk);
    #1;
    modelCommand(c, l, s);
    checkAll(tag);
  endtask

  task automatic buttons(string tag, bit lb, bit rb);
    leftN  = lb;
    rightN = rb;
    #1;
    check(tag, 32'(scOut), 32'(expectedSide()));
  endtask

  initial begin
    // Reset
    rst    = 1'b1;
    clearN = 1'b1;
    loadN  = 1'b1;
    sel    = 2'b11;
    leftN  = 1'b1;
    rightN = 1'b1;
    #25;
    modelReset();
    checkAll("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clear, then load
    step("clear", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
    step("load",  1'b1, 1'b0, 2'b11, 1'b1, 1'b1);

    // Left to the edge and one more
    for (int i = 0; i < 4; i++) step("left", 1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
    buttons("side_left_btn", 1'b0, 1'b1);
    buttons("side_right_btn", 1'b1, 1'b0);
    buttons("side_both_btn", 1'b0, 1'b0);
    step("hold_at_left", 1'b1, 1'b1, 2'b11, 1'b0, 1'b1);

    // Clear, load, right to the edge and one more
    step("clear2", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
    step("load2",  1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("right", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    buttons("side_right_edge_left_btn", 1'b0, 1'b1);

    // Illegal select: sticky error until clear
    step("illegal", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    step("err_sticky_hold", 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    step("err_sticky_shift", 1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
    step("clear_err", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);

    // Clear and load together
    step("clear_load", 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);

    // Async reset in the middle of a shift sequence
    step("load3", 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    step("midshift", 1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
    step("midshift", 1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
    sel = 2'b11;
    #5;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelCommand(1'b1, 1'b1, 2'b11);
    checkAll("after_reset");

    // Shifts on an empty register saturate the counter
    for (int i = 0; i < 260; i++) step("empty_shift", 1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1);
    check("count_saturated", 32'(cntOut), 32'(CNTMAX));
    step("load_keeps_count", 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    step("clear_count", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);

    // Edge wrap (or block) from the MSB and from bit 0
    step("load4", 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("wrap_left", 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step("wrap_right", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);

    // Random commands
    for (int i = 0; i < 250; i++) begin
      int r;
      bit c, l;
      r = int'($urandom_range(0, 99));
      c = !(r < 6);
      l = !((r < 2) || (r >= 6 && r < 16));
      step("random", c, l, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    // Final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
